// File: rtl/karaoke_pkg.sv
// Shared types and constants for the karaoke song timer.
// Holds the timer state encoding, MM:SS limits and the MM:SS-to-decimal helper.
package karaoke_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        DONE    = 2'd3
    } timer_state_e;

    localparam int         SEC_PER_MIN = 60;
    localparam logic [6:0] MAX_MIN     = 7'd99;
    localparam logic [5:0] MAX_SEC     = 6'(SEC_PER_MIN - 1);

    // minutes*100 + seconds built from shifts (64 + 32 + 4) so no multiplier is needed
    function automatic logic [13:0] mm_ss_to_number(input logic [6:0] mm, input logic [5:0] ss);
        return 14'({mm, 6'b0}) + 14'({mm, 5'b0}) + 14'({mm, 2'b0}) + 14'(ss);
    endfunction

endpackage

// File: rtl/song_timer_if.sv
// Control and display bundle between the karaoke front panel and song_timer.
// master drives buttons and song limit; slave (the timer) drives display and status.
interface song_timer_if;
    logic        start_pause;
    logic        clear;
    logic [6:0]  limit_min;
    logic [5:0]  limit_sec;
    logic [15:0] displayed_number;
    logic        running;
    logic        done;
    logic        sec_tick;

    modport master (
        output start_pause, clear, limit_min, limit_sec,
        input  displayed_number, running, done, sec_tick
    );

    modport slave (
        input  start_pause, clear, limit_min, limit_sec,
        output displayed_number, running, done, sec_tick
    );
endinterface

// File: rtl/song_timer_button_conditioner.sv
// Raw button to one-cycle rising-edge pulse: 2-flop synchronizer, optional level
// filter (SONG_TIMER_DEBOUNCE_EN, stable for DEBOUNCE_CYCLES), then edge detect.
module button_conditioner
`ifdef SONG_TIMER_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
)
`endif
(
    input  logic clock_100Mhz,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic sync_1;
    logic sync_2;
    logic filtered;
    logic filtered_prev;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= level;
            sync_2 <= sync_1;
        end
    end

`ifdef SONG_TIMER_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] STABLE_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] stable_count;

    // Any bounce back to the filtered level restarts the stability window.
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            filtered     <= 1'b0;
            stable_count <= '0;
        end else if (sync_2 == filtered) begin
            stable_count <= '0;
        end else if (stable_count == STABLE_LAST) begin
            filtered     <= sync_2;
            stable_count <= '0;
        end else begin
            stable_count <= stable_count + CW'(1);
        end
    end
`else
    assign filtered = sync_2;
`endif

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            filtered_prev <= 1'b0;
        end else begin
            filtered_prev <= filtered;
        end
    end

    assign pulse = filtered & ~filtered_prev;

endmodule

// File: rtl/song_timer.sv
// Elapsed MM:SS timer for the current karaoke song, shown as minutes*100+seconds.
// Define SONG_TIMER_DEBOUNCE_EN to add the DEBOUNCE_CYCLES button filter.
module song_timer
    import karaoke_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
`ifdef SONG_TIMER_DEBOUNCE_EN
    , parameter int DEBOUNCE_CYCLES = 1_000_000
`endif
) (
    input  logic        clock_100Mhz,
    input  logic        reset,
    song_timer_if.slave bus
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    timer_state_e  state;
    timer_state_e  state_next;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_next;
    logic [6:0]    min_count;
    logic [6:0]    min_next;
    logic [6:0]    min_inc;
    logic [5:0]    sec_count;
    logic [5:0]    sec_next;
    logic [5:0]    sec_inc;
    logic          tick;
    logic          limit_set;
    logic          terminal;
    logic          start_pulse;
    logic          clear_pulse;
    logic [15:0]   displayed_number_q;
    logic          running_q;
    logic          done_q;
    logic          sec_tick_q;

    button_conditioner
`ifdef SONG_TIMER_DEBOUNCE_EN
    #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
    u_start_button (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .level        (bus.start_pause),
        .pulse        (start_pulse)
    );

    button_conditioner
`ifdef SONG_TIMER_DEBOUNCE_EN
    #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
    u_clear_button (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .level        (bus.clear),
        .pulse        (clear_pulse)
    );

    // Value the counters take if this cycle's tick is counted; terminal checks use it.
    assign sec_inc   = (sec_count == MAX_SEC) ? 6'd0 : sec_count + 6'd1;
    assign min_inc   = (sec_count == MAX_SEC) ? min_count + 7'd1 : min_count;
    assign limit_set = (bus.limit_min != 7'd0) || (bus.limit_sec != 6'd0);
    assign terminal  = (limit_set && min_inc == bus.limit_min && sec_inc == bus.limit_sec)
                    || (min_inc == MAX_MIN && sec_inc == MAX_SEC);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        presc_next = presc;
        min_next   = min_count;
        sec_next   = sec_count;
        tick       = 1'b0;

        case (state)
            IDLE: begin
                presc_next = '0;
                if (start_pulse) state_next = RUNNING;
            end
            RUNNING: begin
                if (presc == PRESC_MAX) begin
                    presc_next = '0;
                    tick       = 1'b1;
                    min_next   = min_inc;
                    sec_next   = sec_inc;
                end else begin
                    presc_next = presc + PW'(1);
                end
                if (tick && terminal)  state_next = DONE;
                else if (start_pulse)  state_next = PAUSED;
            end
            PAUSED: begin
                if (start_pulse) state_next = RUNNING;
            end
            DONE: ;
            default: state_next = IDLE;
        endcase

        // Clear outranks start and tick in every state.
        if (clear_pulse) begin
            state_next = IDLE;
            presc_next = '0;
            min_next   = 7'd0;
            sec_next   = 6'd0;
            tick       = 1'b0;
        end
    end

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            presc              <= '0;
            min_count          <= 7'd0;
            sec_count          <= 6'd0;
            sec_tick_q         <= 1'b0;
            running_q          <= 1'b0;
            done_q             <= 1'b0;
            displayed_number_q <= 16'd0;
        end else begin
            state              <= state_next;
            presc              <= presc_next;
            min_count          <= min_next;
            sec_count          <= sec_next;
            sec_tick_q         <= tick;
            running_q          <= (state_next == RUNNING);
            done_q             <= (state_next == DONE);
            displayed_number_q <= {2'b00, mm_ss_to_number(min_count, sec_count)};
        end
    end

    assign bus.displayed_number = displayed_number_q;
    assign bus.running          = running_q;
    assign bus.done             = done_q;
    assign bus.sec_tick         = sec_tick_q;

endmodule

// File: tb/tb_song_timer.sv
// Self-checking bench for song_timer with TICK_DIV=4; a seconds model feeds a
// scoreboard of expected displayed_number values checked the cycle after each tick.
module tb_song_timer;

    localparam int TICK_DIV = 4;
`ifdef SONG_TIMER_DEBOUNCE_EN
    localparam int DEB = 8;
    localparam int LAT = 3 + DEB;
`else
    localparam int LAT = 3;
`endif
    // Press lead after a tick so the pause lands with the prescaler at 2.
    localparam int PAUSE_LEAD = ((2 - LAT) % TICK_DIV + TICK_DIV) % TICK_DIV;

    logic clock_100Mhz = 1'b0;
    logic reset;

    always #5 clock_100Mhz = ~clock_100Mhz;

    song_timer_if bus ();

    song_timer #(
        .TICK_DIV(TICK_DIV)
`ifdef SONG_TIMER_DEBOUNCE_EN
        , .DEBOUNCE_CYCLES(DEB)
`endif
    ) dut (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .bus          (bus)
    );

    int total      = 0;
    int bad        = 0;
    int tick_count = 0;
    int model_secs = 0;
    int exp_q[$];

    function automatic int model_number(input int s);
        return (s / 60) * 100 + (s % 60);
    endfunction

    // One clock: score any pending display expectation, then record a new tick.
    task automatic cycle();
        int want;
        @(negedge clock_100Mhz);
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            total++;
            if (bus.displayed_number !== 16'(want)) begin
                bad++;
                $display("FAIL display_after_tick: got %0d want %0d", bus.displayed_number, want);
            end
        end
        if (bus.sec_tick === 1'b1) begin
            tick_count++;
            model_secs++;
            exp_q.push_back(model_number(model_secs));
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) cycle();
    endtask

    task automatic run_ticks(input int n, input string tag);
        int target;
        int spent;
        target = tick_count + n;
        spent  = 0;
        while (tick_count < target && spent < n * TICK_DIV + 20) begin
            cycle();
            spent++;
        end
        total++;
        if (tick_count != target) begin
            bad++;
            $display("FAIL %s tick_count: got %0d want %0d", tag, tick_count, target);
        end
    endtask

    task automatic press_start();
        bus.start_pause = 1'b1;
        cycles(LAT);
        bus.start_pause = 1'b0;
    endtask

    task automatic press_clear();
        bus.clear = 1'b1;
        cycles(LAT);
        bus.clear = 1'b0;
        model_secs = 0;
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        bus.start_pause = 1'b0;
        bus.clear       = 1'b0;
        bus.limit_min   = 7'd0;
        bus.limit_sec   = 6'd0;
        cycles(3);
        total++; if (bus.displayed_number !== 16'd0) begin bad++; $display("FAIL reset_display: got %0d want 0", bus.displayed_number); end
        total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL reset_running: got %b want 0", bus.running); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        total++; if (bus.sec_tick !== 1'b0) begin bad++; $display("FAIL reset_sec_tick: got %b want 0", bus.sec_tick); end
        reset = 1'b0;
        cycles(3);
    endtask

    task automatic test_run_count();
        bus.start_pause = 1'b1;
        cycles(LAT - 1);
        total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL start_early: got %b want 0", bus.running); end
        cycle();
        total++; if (bus.running !== 1'b1) begin bad++; $display("FAIL start_latency: got %b want 1", bus.running); end
        bus.start_pause = 1'b0;
        run_ticks(75, "count75");
        cycle();
        total++; if (bus.displayed_number !== 16'd115) begin bad++; $display("FAIL count75_display: got %0d want 115", bus.displayed_number); end
    endtask

    task automatic test_pause_resume();
        int spent;
        int snap;
        spent = 0;
        while (bus.sec_tick !== 1'b1 && spent < 2 * TICK_DIV) begin
            cycle();
            spent++;
        end
        total++; if (bus.sec_tick !== 1'b1) begin bad++; $display("FAIL pause_align: got %b want 1", bus.sec_tick); end
        cycles(PAUSE_LEAD);
        press_start();
        total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL pause_running: got %b want 0", bus.running); end
        snap = tick_count;
        cycles(20);
        total++; if (tick_count != snap) begin bad++; $display("FAIL paused_ticks: got %0d want %0d", tick_count, snap); end
        total++; if (bus.displayed_number !== 16'(model_number(model_secs))) begin
            bad++; $display("FAIL paused_display: got %0d want %0d", bus.displayed_number, model_number(model_secs));
        end
        press_start();
        total++; if (bus.running !== 1'b1) begin bad++; $display("FAIL resume_running: got %b want 1", bus.running); end
        cycle();
        total++; if (bus.sec_tick !== 1'b0) begin bad++; $display("FAIL resume_tick_early: got %b want 0", bus.sec_tick); end
        cycle();
        total++; if (bus.sec_tick !== 1'b1) begin bad++; $display("FAIL resume_tick_at_2: got %b want 1", bus.sec_tick); end
    endtask

    task automatic test_limit();
        int snap;
        press_clear();
        total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL clear_running: got %b want 0", bus.running); end
        cycle();
        total++; if (bus.displayed_number !== 16'd0) begin bad++; $display("FAIL clear_display: got %0d want 0", bus.displayed_number); end
        bus.limit_min = 7'd2;
        bus.limit_sec = 6'd30;
        press_start();
        run_ticks(149, "limit_149");
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL limit_early_done: got %b want 0", bus.done); end
        run_ticks(1, "limit_150");
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL limit_done: got %b want 1", bus.done); end
        total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL limit_running: got %b want 0", bus.running); end
        cycle();
        total++; if (bus.displayed_number !== 16'd230) begin bad++; $display("FAIL limit_display: got %0d want 230", bus.displayed_number); end
        snap = tick_count;
        cycles(8);
        total++; if (tick_count != snap) begin bad++; $display("FAIL limit_frozen: got %0d want %0d", tick_count, snap); end
        press_clear();
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL limit_clear_done: got %b want 0", bus.done); end
        cycle();
        total++; if (bus.displayed_number !== 16'd0) begin bad++; $display("FAIL limit_clear_display: got %0d want 0", bus.displayed_number); end
    endtask

    task automatic test_full_run();
        int snap;
        bus.limit_min = 7'd0;
        bus.limit_sec = 6'd0;
        cycles(4);
        press_start();
        run_ticks(5998, "full_5998");
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL full_early_done: got %b want 0", bus.done); end
        run_ticks(1, "full_5999");
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL full_done: got %b want 1", bus.done); end
        cycle();
        total++; if (bus.displayed_number !== 16'd9959) begin bad++; $display("FAIL full_display: got %0d want 9959", bus.displayed_number); end
        snap = tick_count;
        press_start();
        cycles(10);
        total++; if (tick_count != snap) begin bad++; $display("FAIL full_frozen: got %0d want %0d", tick_count, snap); end
        total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL full_start_ignored: got %b want 0", bus.running); end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL full_still_done: got %b want 1", bus.done); end
        press_clear();
        cycles(2);
    endtask

    task automatic test_clear_start_same();
        press_start();
        run_ticks(3, "same_run");
        cycles(2);
        press_start();
        total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL same_paused: got %b want 0", bus.running); end
        cycles(4);
        bus.start_pause = 1'b1;
        bus.clear       = 1'b1;
        cycles(LAT);
        bus.start_pause = 1'b0;
        bus.clear       = 1'b0;
        model_secs      = 0;
        total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL same_running: got %b want 0", bus.running); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL same_done: got %b want 0", bus.done); end
        cycle();
        total++; if (bus.displayed_number !== 16'd0) begin bad++; $display("FAIL same_display: got %0d want 0", bus.displayed_number); end
        cycles(4);
    endtask

    task automatic test_reset_mid_run();
        press_start();
        run_ticks(3, "mid_run");
        cycle();
        total++; if (bus.running !== 1'b1) begin bad++; $display("FAIL mid_running_before: got %b want 1", bus.running); end
        reset = 1'b1;
        #1;
        total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL mid_reset_running: got %b want 0", bus.running); end
        total++; if (bus.displayed_number !== 16'd0) begin bad++; $display("FAIL mid_reset_display: got %0d want 0", bus.displayed_number); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL mid_reset_done: got %b want 0", bus.done); end
        total++; if (bus.sec_tick !== 1'b0) begin bad++; $display("FAIL mid_reset_tick: got %b want 0", bus.sec_tick); end
        model_secs = 0;
        cycles(2);
        reset = 1'b0;
        cycles(3);
        press_start();
        run_ticks(1, "after_reset");
        cycle();
        total++; if (bus.displayed_number !== 16'd1) begin bad++; $display("FAIL after_reset_display: got %0d want 1", bus.displayed_number); end
    endtask

`ifdef SONG_TIMER_DEBOUNCE_EN
    task automatic test_debounce_glitch();
        press_clear();
        cycles(4);
        bus.start_pause = 1'b1;
        cycles(5);
        bus.start_pause = 1'b0;
        cycles(20);
        total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL glitch_running: got %b want 0", bus.running); end
        press_start();
        total++; if (bus.running !== 1'b1) begin bad++; $display("FAIL debounced_press: got %b want 1", bus.running); end
    endtask
`endif

    initial begin
        test_reset();
        test_run_count();
        test_pause_resume();
        test_limit();
        test_full_run();
        test_clear_start_same();
        test_reset_mid_run();
`ifdef SONG_TIMER_DEBOUNCE_EN
        test_debounce_glitch();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
